// File: rtl/board_store_pkg.sv
// Shared constants and FSM encoding for the five-in-a-row board store.
package board_store_pkg;

    localparam int DIM_LOG2_DEFAULT = 4;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] BLACK = 2'd1;
    localparam logic [1:0] WHITE = 2'd2;

    localparam logic [1:0] REJ_NONE     = 2'd0;
    localparam logic [1:0] REJ_OCCUPIED = 2'd1;
    localparam logic [1:0] REJ_TURN     = 2'd2;
    localparam logic [1:0] REJ_PIECE    = 2'd3;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CHECK = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    function automatic logic [1:0] other_side(input logic [1:0] c);
        return (c == BLACK) ? WHITE : BLACK;
    endfunction

endpackage

// File: rtl/board_store_if.sv
// Bus between the board store, the move source and the line checkers.
// Move handshake: a move transfers on a clock edge where move_valid && move_ready are both high;
// the source holds move_ptr/move_chess stable while move_valid is high, and the store answers one
// cycle later with exactly one of move_ack / move_reject (or neither when the game is over).
interface board_store_if #(
    parameter int ADDR_W = 8
);
    logic              new_game;
    logic              move_valid;
    logic [ADDR_W-1:0] move_ptr;
    logic [1:0]        move_chess;
    logic              move_ready;
    logic              move_ack;
    logic              move_reject;
    logic [1:0]        reject_code;
    logic [ADDR_W-1:0] rd_addr;
    logic [1:0]        rd_state;
    logic              check_start;
    logic [ADDR_W-1:0] check_ptr;
    logic [1:0]        check_chess;
    logic              check_done;
    logic              check_win;
    logic              game_over;
    logic [1:0]        winner;
    logic [ADDR_W:0]   move_count;

    modport master (
        output new_game, move_valid, move_ptr, move_chess, rd_addr, check_done, check_win,
        input  move_ready, move_ack, move_reject, reject_code, rd_state, check_start,
               check_ptr, check_chess, game_over, winner, move_count
    );

    modport slave (
        input  new_game, move_valid, move_ptr, move_chess, rd_addr, check_done, check_win,
        output move_ready, move_ack, move_reject, reject_code, rd_state, check_start,
               check_ptr, check_chess, game_over, winner, move_count
    );
endinterface

// File: rtl/board_ram.sv
// Board cell array: two combinational read ports (checkers, occupancy) and one synchronous write.
module board_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        rd_data,
    input  logic [ADDR_W-1:0] occ_addr,
    output logic [1:0]        occ_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [1:0]        wdata
);
    logic [1:0] mem [2**ADDR_W];

    // No reset on the array; the controller sweeps it clear instead.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rd_data  = mem[rd_addr];
    assign occ_data = mem[occ_addr];
endmodule

// File: rtl/board_store.sv
// Board-state store and move-commit controller: clears the board, validates and commits moves,
// then hands each committed move to the line checkers and records the game outcome.
module board_store
    import board_store_pkg::*;
#(
    parameter int DIM_LOG2     = DIM_LOG2_DEFAULT,
    parameter bit ENFORCE_TURN = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    board_store_if.slave  bus,
    output state_t        dbg_state
);
    localparam int              ADDR_W     = 2 * DIM_LOG2;
    localparam int              CELLS      = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(CELLS);

    state_t            state;
    logic [ADDR_W-1:0] sweep;
    logic [1:0]        turn;
    logic              ack_q, rej_q, start_q, over_q;
    logic [1:0]        code_q, chess_q, winner_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   count_q;

    logic [1:0]        ram_rd, occ_state, ram_wdata, rej_code_c;
    logic [ADDR_W-1:0] ram_waddr;
    logic              ram_we, take_c, accept_c;

    board_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk      (clk),
        .rd_addr  (bus.rd_addr),
        .rd_data  (ram_rd),
        .occ_addr (bus.move_ptr),
        .occ_data (occ_state),
        .we       (ram_we),
        .waddr    (ram_waddr),
        .wdata    (ram_wdata)
    );

    // Move classification in priority order: bad piece, wrong turn, occupied cell.
    always_comb begin
        take_c     = (state == ST_IDLE) && bus.move_valid && !bus.new_game;
        rej_code_c = REJ_NONE;
        if (bus.move_chess == EMPTY || bus.move_chess == 2'd3) rej_code_c = REJ_PIECE;
        else if (ENFORCE_TURN && bus.move_chess != turn)       rej_code_c = REJ_TURN;
        else if (occ_state != EMPTY)                           rej_code_c = REJ_OCCUPIED;
        accept_c  = take_c && (rej_code_c == REJ_NONE);

        ram_we    = 1'b0;
        ram_waddr = bus.move_ptr;
        ram_wdata = bus.move_chess;
        if (state == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = sweep;
            ram_wdata = EMPTY;
        end else if (accept_c) begin
            ram_we = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_CLEAR;
            sweep    <= '0;
            turn     <= BLACK;
            ack_q    <= 1'b0;
            rej_q    <= 1'b0;
            code_q   <= REJ_NONE;
            start_q  <= 1'b0;
            ptr_q    <= '0;
            chess_q  <= EMPTY;
            over_q   <= 1'b0;
            winner_q <= EMPTY;
            count_q  <= '0;
        end else begin
            ack_q <= 1'b0;
            rej_q <= 1'b0;
            if (bus.new_game) begin
                state    <= ST_CLEAR;
                sweep    <= '0;
                turn     <= BLACK;
                code_q   <= REJ_NONE;
                start_q  <= 1'b0;
                over_q   <= 1'b0;
                winner_q <= EMPTY;
                count_q  <= '0;
            end else begin
                case (state)
                    ST_CLEAR: begin
                        sweep <= sweep + 1'b1;
                        if (sweep == '1) state <= ST_IDLE;
                    end
                    ST_IDLE: begin
                        if (accept_c) begin
                            ack_q   <= 1'b1;
                            code_q  <= REJ_NONE;
                            ptr_q   <= bus.move_ptr;
                            chess_q <= bus.move_chess;
                            start_q <= 1'b1;
                            turn    <= other_side(turn);
                            if (count_q < FULL_COUNT) count_q <= count_q + 1'b1;
                            state   <= ST_CHECK;
                        end else if (take_c) begin
                            rej_q  <= 1'b1;
                            code_q <= rej_code_c;
                        end
                    end
                    ST_CHECK: begin
                        if (bus.check_done) begin
                            start_q <= 1'b0;
                            if (bus.check_win) begin
                                over_q   <= 1'b1;
                                winner_q <= chess_q;
                                state    <= ST_OVER;
                            end else if (count_q == FULL_COUNT) begin
                                over_q   <= 1'b1;
                                winner_q <= EMPTY;
                                state    <= ST_OVER;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    ST_OVER: ;
                    default: state <= ST_CLEAR;
                endcase
            end
        end
    end

    assign bus.move_ready  = (state == ST_IDLE);
    assign bus.move_ack    = ack_q;
    assign bus.move_reject = rej_q;
    assign bus.reject_code = code_q;
    assign bus.rd_state    = (state == ST_CLEAR) ? EMPTY : ram_rd;
    assign bus.check_start = start_q;
    assign bus.check_ptr   = ptr_q;
    assign bus.check_chess = chess_q;
    assign bus.game_over   = over_q;
    assign bus.winner      = winner_q;
    assign bus.move_count  = count_q;
    assign dbg_state       = state;
endmodule
